// File: rtl/wavelet_pkg.sv
// Shared types and geometry for the inverse 5/3 wavelet line reconstructor.
package wavelet_pkg;

    localparam int unsigned COEF_W      = 16;
    localparam int unsigned ADDR_W      = 12;
    localparam int unsigned PAIRS_M0    = 32;
    localparam int unsigned PAIRS_M1    = 16;
    localparam int unsigned LINES_M0    = 64;
    localparam int unsigned LINES_M1    = 32;
    localparam int unsigned LINE_STRIDE = 64;
    localparam int unsigned LINE_SHIFT  = $clog2(LINE_STRIDE);
    localparam int unsigned IDX_W       = 5;
    localparam int unsigned LINE_W      = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_TAIL,
        ST_NEXT,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [COEF_W-1:0] even;
        logic [COEF_W-1:0] odd;
        logic [ADDR_W-1:0] addr;
    } out_pair_t;

    function automatic int unsigned pairs_for(input logic mode);
        return mode ? PAIRS_M1 : PAIRS_M0;
    endfunction

    function automatic int unsigned lines_for(input logic mode);
        return mode ? LINES_M1 : LINES_M0;
    endfunction

endpackage

// File: rtl/wavelet_inverse_if.sv
// Control, coefficient-read and reconstructed-sample bus of the inverse wavelet block.
interface wavelet_inverse_if;

    logic                               start;
    logic                               wavelet_mode;
    logic [wavelet_pkg::COEF_W-1:0]     coef_low;
    logic [wavelet_pkg::COEF_W-1:0]     coef_high;
    logic                               coef_rd;
    logic [wavelet_pkg::ADDR_W-1:0]     low_address;
    logic [wavelet_pkg::ADDR_W-1:0]     high_address;
    logic [wavelet_pkg::COEF_W-1:0]     data_out_even;
    logic [wavelet_pkg::COEF_W-1:0]     data_out_odd;
    logic [wavelet_pkg::ADDR_W-1:0]     out_address;
    logic                               output_valid;
    logic                               busy;
    logic                               done;

    modport master (
        output start, wavelet_mode, coef_low, coef_high,
        input  coef_rd, low_address, high_address, data_out_even, data_out_odd,
               out_address, output_valid, busy, done
    );

    modport slave (
        input  start, wavelet_mode, coef_low, coef_high,
        output coef_rd, low_address, high_address, data_out_even, data_out_odd,
               out_address, output_valid, busy, done
    );

endinterface

// File: rtl/wavelet_inv_lift.sv
// Combinational inverse lifting: even update from s/d, odd predict from neighbouring evens.
module wavelet_inv_lift
    import wavelet_pkg::*;
(
    input  logic signed [COEF_W-1:0] s,
    input  logic signed [COEF_W-1:0] d,
    input  logic signed [COEF_W-1:0] d_prev,
    input  logic signed [COEF_W-1:0] e_prev,
    input  logic                     tail,
    output logic signed [COEF_W-1:0] e,
    output logic signed [COEF_W-1:0] o
);

    localparam int unsigned SUM_W = COEF_W + 2;

    logic signed [SUM_W-1:0] d_sum;
    logic signed [SUM_W-1:0] e_full;
    logic signed [SUM_W-1:0] e_sum;
    logic signed [SUM_W-1:0] o_full;

    // Arithmetic shifts give floor division; final results wrap to 16 bits.
    always_comb begin
        d_sum  = SUM_W'(d_prev) + SUM_W'(d) + SUM_W'(2);
        e_full = SUM_W'(s) - (d_sum >>> 2);
        e      = COEF_W'(e_full);
        e_sum  = SUM_W'(e_prev) + SUM_W'(e);
        o_full = tail ? (SUM_W'(d_prev) + SUM_W'(e_prev))
                      : (SUM_W'(d_prev) + (e_sum >>> 1));
        o      = COEF_W'(o_full);
    end

endmodule

// File: rtl/wavelet_inverse.sv
// Inverse 5/3 wavelet tile reconstructor: line sequencer, coefficient reads and output pairs.
module wavelet_inverse
    import wavelet_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    wavelet_inverse_if.slave bus
);

    state_e                   state_q, state_d;
    logic                     mode_q, mode_d;
    logic [LINE_W-1:0]        line_q, line_d;
    logic [IDX_W-1:0]         index_q, index_d;
    logic signed [COEF_W-1:0] d_prev_q, d_prev_d;
    logic signed [COEF_W-1:0] e_prev_q, e_prev_d;
    out_pair_t                out_q, out_d;
    logic                     valid_q, valid_d;
    logic                     coef_rd_q, coef_rd_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [ADDR_W-1:0]        low_addr_q, low_addr_d;
    logic [ADDR_W-1:0]        high_addr_q, high_addr_d;

    logic [IDX_W-1:0]         last_idx;
    logic [LINE_W-1:0]        last_line;
    logic [IDX_W-1:0]         pair_idx;
    logic                     arrive, first, tail, emit;
    logic signed [COEF_W-1:0] lift_dprev, lift_e, lift_o;

    wavelet_inv_lift u_lift (
        .s      (bus.coef_low),
        .d      (bus.coef_high),
        .d_prev (lift_dprev),
        .e_prev (e_prev_q),
        .tail   (tail),
        .e      (lift_e),
        .o      (lift_o)
    );

    // Coefficients land one cycle after their read; pair n-1 is emitted when index n lands.
    always_comb begin
        last_idx   = IDX_W'(pairs_for(mode_q) - 1);
        last_line  = LINE_W'(lines_for(mode_q) - 1);
        arrive     = ((state_q == ST_READ) && (index_q != '0)) || (state_q == ST_DRAIN);
        first      = (state_q == ST_READ) && (index_q == IDX_W'(1));
        tail       = (state_q == ST_TAIL);
        emit       = (arrive && !first) || tail;
        lift_dprev = first ? bus.coef_high : d_prev_q;
        if (tail) begin
            pair_idx = last_idx;
        end else if (state_q == ST_DRAIN) begin
            pair_idx = last_idx - IDX_W'(1);
        end else begin
            pair_idx = index_q - IDX_W'(2);
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        line_d   = line_q;
        index_d  = '0;
        d_prev_d = d_prev_q;
        e_prev_d = e_prev_q;
        out_d    = out_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_READ;
                    mode_d  = bus.wavelet_mode;
                    line_d  = '0;
                end
            end
            ST_READ: begin
                if (index_q == last_idx) begin
                    state_d = ST_DRAIN;
                end else begin
                    index_d = index_q + IDX_W'(1);
                end
            end
            ST_DRAIN: state_d = ST_TAIL;
            ST_TAIL:  state_d = ST_NEXT;
            ST_NEXT: begin
                if (line_q == last_line) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_READ;
                    line_d  = line_q + LINE_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                line_d  = '0;
            end
            default: state_d = ST_IDLE;
        endcase

        if (arrive) begin
            d_prev_d = bus.coef_high;
            e_prev_d = lift_e;
        end
        if (emit) begin
            out_d.even = e_prev_q;
            out_d.odd  = lift_o;
            out_d.addr = (ADDR_W'(line_q) << LINE_SHIFT) + (ADDR_W'(pair_idx) << 1);
        end

        valid_d     = emit;
        coef_rd_d   = (state_d == ST_READ);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        low_addr_d  = (ADDR_W'(line_d) << LINE_SHIFT) + ADDR_W'(index_d);
        high_addr_d = low_addr_d + ADDR_W'(pairs_for(mode_d));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            line_q      <= '0;
            index_q     <= '0;
            d_prev_q    <= '0;
            e_prev_q    <= '0;
            out_q       <= '0;
            valid_q     <= 1'b0;
            coef_rd_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            low_addr_q  <= '0;
            high_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            line_q      <= line_d;
            index_q     <= index_d;
            d_prev_q    <= d_prev_d;
            e_prev_q    <= e_prev_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
            coef_rd_q   <= coef_rd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            low_addr_q  <= low_addr_d;
            high_addr_q <= high_addr_d;
        end
    end

    assign bus.coef_rd       = coef_rd_q;
    assign bus.low_address   = low_addr_q;
    assign bus.high_address  = high_addr_q;
    assign bus.data_out_even = out_q.even;
    assign bus.data_out_odd  = out_q.odd;
    assign bus.out_address   = out_q.addr;
    assign bus.output_valid  = valid_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

endmodule

// File: tb/tb_wavelet_inverse.sv
// Directed bench for wavelet_inverse: constant tiles, forward-5/3 round trips, reset and busy abuse.
module tb_wavelet_inverse;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    logic [15:0] coef_mem [4096];
    logic [15:0] exp_mem  [4096];
    logic [15:0] pend_low, pend_high;

    wavelet_inverse_if bus ();

    wavelet_inverse dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Coefficient RAM model: data for a read seen in one cycle is presented for the whole next cycle.
    initial begin
        pend_low  = 16'hDEAD;
        pend_high = 16'hBEEF;
        forever begin
            @(negedge clk);
            bus.coef_low  = pend_low;
            bus.coef_high = pend_high;
            if (bus.coef_rd) begin
                pend_low  = coef_mem[bus.low_address];
                pend_high = coef_mem[bus.high_address];
            end else begin
                pend_low  = 16'hDEAD;
                pend_high = 16'hBEEF;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_const(input logic mode, input logic [15:0] s, input logic [15:0] d,
                              input logic [15:0] ev, input logic [15:0] od);
        int np = mode ? 16 : 32;
        int nl = mode ? 32 : 64;
        for (int l = 0; l < nl; l++) begin
            for (int n = 0; n < np; n++) begin
                coef_mem[l*64 + n]      = s;
                coef_mem[l*64 + np + n] = d;
                exp_mem[l*64 + 2*n]     = ev;
                exp_mem[l*64 + 2*n + 1] = od;
            end
        end
    endtask

    // Forward 5/3 lifting with 16-bit wrap; the inverse must recover exp_mem exactly.
    task automatic fill_random(input logic mode);
        int np = mode ? 16 : 32;
        int nl = mode ? 32 : 64;
        logic signed [15:0] dd [32];
        logic signed [15:0] dp;
        int xe, xo, xn, t;
        for (int l = 0; l < nl; l++) begin
            for (int i = 0; i < 2*np; i++) begin
                exp_mem[l*64 + i] = 16'($urandom);
                if (i == (l % (2*np)))       exp_mem[l*64 + i] = 16'h7FFF;
                if (i == ((l+5) % (2*np)))   exp_mem[l*64 + i] = 16'h8000;
                if (i == ((l+6) % (2*np)))   exp_mem[l*64 + i] = 16'h7FFE;
            end
            for (int n = 0; n < np; n++) begin
                xe = int'($signed(exp_mem[l*64 + 2*n]));
                xo = int'($signed(exp_mem[l*64 + 2*n + 1]));
                xn = (n == np-1) ? xe : int'($signed(exp_mem[l*64 + 2*n + 2]));
                t  = xo - ((xe + xn) >>> 1);
                dd[n] = 16'(t);
            end
            for (int n = 0; n < np; n++) begin
                xe = int'($signed(exp_mem[l*64 + 2*n]));
                dp = (n == 0) ? dd[0] : dd[n-1];
                t  = xe + ((int'(dp) + int'(dd[n]) + 2) >>> 2);
                coef_mem[l*64 + n]      = 16'(t);
                coef_mem[l*64 + np + n] = dd[n];
            end
        end
    endtask

    // Start a tile and check every cycle against the fixed line schedule.
    task automatic run_tile(input logic mode, input int abort_k, input bit disturb);
        int np = mode ? 16 : 32;
        int nl = mode ? 32 : 64;
        int per = np + 3;
        int total = nl * per;
        int pairs = 0;
        int dones = 0;
        int line, pos, addr;
        bit aborted = 1'b0;
        chk("idle_before_start", 32'(bus.busy), 32'd0);
        bus.wavelet_mode = mode;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k <= total + 2; k++) begin
            if (k == abort_k) begin
                aborted = 1'b1;
                break;
            end
            line = k / per;
            pos  = k % per;
            if (k < total) begin
                chk("coef_rd", 32'(bus.coef_rd), 32'(pos < np));
                chk("output_valid", 32'(bus.output_valid), 32'(pos >= 3));
                chk("busy", 32'(bus.busy), 32'd1);
                chk("done_early", 32'(bus.done), 32'd0);
                if (pos < np) begin
                    chk("low_address", 32'(bus.low_address), 32'(line*64 + pos));
                    chk("high_address", 32'(bus.high_address), 32'(line*64 + np + pos));
                end
                if (pos >= 3) begin
                    pairs++;
                    addr = line*64 + 2*(pos-3);
                    chk("out_address", 32'(bus.out_address), 32'(addr));
                    chk("data_even", 32'(bus.data_out_even), 32'(exp_mem[addr]));
                    chk("data_odd", 32'(bus.data_out_odd), 32'(exp_mem[addr+1]));
                end
                if (!mode && k == 5*per + 3) begin
                    chk("l5n3_low", 32'(bus.low_address), 32'd323);
                    chk("l5n3_high", 32'(bus.high_address), 32'd355);
                end
                if (!mode && k == 5*per + 6)
                    chk("l5n3_out", 32'(bus.out_address), 32'd326);
            end else if (k == total) begin
                chk("done_pulse", 32'(bus.done), 32'd1);
                chk("done_busy", 32'(bus.busy), 32'd1);
                chk("done_valid", 32'(bus.output_valid), 32'd0);
                chk("done_rd", 32'(bus.coef_rd), 32'd0);
            end else begin
                chk("idle_done", 32'(bus.done), 32'd0);
                chk("idle_busy", 32'(bus.busy), 32'd0);
                chk("idle_valid", 32'(bus.output_valid), 32'd0);
            end
            if (bus.done) dones++;
            if (disturb) begin
                bus.start = (k == 40 || k == 300);
                if (k == 100) bus.wavelet_mode = ~mode;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (!aborted) begin
            chk("pair_count", 32'(pairs), 32'(nl*np));
            chk("done_count", 32'(dones), 32'd1);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_even"}, 32'(bus.data_out_even), 32'd0);
        chk({tag, "_odd"}, 32'(bus.data_out_odd), 32'd0);
        chk({tag, "_outaddr"}, 32'(bus.out_address), 32'd0);
        chk({tag, "_low"}, 32'(bus.low_address), 32'd0);
        chk({tag, "_high"}, 32'(bus.high_address), 32'd0);
        chk({tag, "_valid"}, 32'(bus.output_valid), 32'd0);
        chk({tag, "_rd"}, 32'(bus.coef_rd), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.wavelet_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_reset_busy", 32'(bus.busy), 32'd0);
        chk("post_reset_rd", 32'(bus.coef_rd), 32'd0);

        fill_const(1'b1, 16'd10, 16'd4, 16'd8, 16'd12);
        run_tile(1'b1, -1, 1'b0);

        fill_const(1'b1, 16'd0, 16'hFFFD, 16'd1, 16'hFFFE);
        run_tile(1'b1, -1, 1'b0);

        fill_random(1'b0);
        run_tile(1'b0, -1, 1'b0);

        fill_random(1'b1);
        run_tile(1'b1, -1, 1'b1);

        fill_random(1'b0);
        run_tile(1'b0, 400, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midline_rst");
        @(negedge clk);
        chk_zero_outputs("held_rst");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_idle_busy", 32'(bus.busy), 32'd0);
        chk("rst_idle_rd", 32'(bus.coef_rd), 32'd0);
        chk("rst_idle_valid", 32'(bus.output_valid), 32'd0);

        fill_random(1'b1);
        run_tile(1'b1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
